clk_gate_ctrl: RTL and testbench

- Control side of the integrated clock-gating cell: produces the registered, glitch-free enable that drives the ICG en_i input for one gateable sub-domain.
- Monitors domain activity and gates the sub-domain clock after a programmable number of consecutive idle cycles.
- Ungates the clock on an incoming request or wake event, then holds off requesters until a fixed settle window has elapsed.
- Sits in the always-on clock domain, next to the ICG it controls.

---
 rtl/clk_gate_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
//
// Control side of an integrated clock-gating cell for one gateable
// sub-domain. Lives in the always-on clock domain. It watches the
// domain's activity, and after a programmable number of consecutive idle
// cycles it drops the ICG enable. A request, a wake event or a debug
// override brings the clock back. Requesters are held off until a fixed
// settle window has elapsed.
//
// The ICG enable comes straight from a flop, so the enable the ICG latches
// carries no combinational glitches. ready_o and gated_o are decoded only
// from the state register.
//
// Ports
//   clk_i        always-on clock (ungated side of the ICG)
//   rst_i        synchronous, active-high reset
//   auto_en_i    enables automatic idle gating
//   idle_thr_i   consecutive idle cycles before gating (0 = never gate)
//   busy_i       gated domain reports activity
//   req_i        upstream transfer request into the gated domain
//   ready_o      gated domain is clocked and may accept req_i
//   wake_i       external wake event (interrupt/debug)
//   force_on_i   test/debug override, keeps the clock running
//   clk_en_o     enable to the ICG, registered
//   gated_o      status: clock currently gated
//   dbg_state_o     current FSM state (RUN=0, IDLE_WAIT=1, GATED=2, WAKE=3)
//   dbg_idle_cnt_o  current idle counter
//   dbg_wake_cnt_o  current wake settle counter
//
// Handshake: a transfer completes on any rising edge where req_i && ready_o.
// A requester holds req_i stable until it sees ready_o. A request that
// arrives while the domain is gated wakes the domain. It completes on the
// first RUN cycle after the settle window.
// ---------------------------------------------------------------------------
module clk_gate_ctrl #(
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2,
    localparam int WCW        = $clog2(WAKE_CYCLES) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             auto_en_i,
    input  logic [CNT_W-1:0] idle_thr_i,
    input  logic             busy_i,
    input  logic             req_i,
    output logic             ready_o,
    input  logic             wake_i,
    input  logic             force_on_i,
    output logic             clk_en_o,
    output logic             gated_o,
    output logic [1:0]       dbg_state_o,
    output logic [CNT_W-1:0] dbg_idle_cnt_o,
    output logic [WCW-1:0]   dbg_wake_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GATED     = 2'd2,
        ST_WAKE      = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] IDLE_MAX  = {CNT_W{1'b1}};
    localparam logic [WCW-1:0]   WAKE_LAST = WCW'(WAKE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WCW-1:0]   wake_cnt_q, wake_cnt_d;
    logic             clk_en_q, clk_en_d;

    logic             idle_cycle;
    logic             wake_req;
    logic [CNT_W:0]   idle_cnt_inc;   // one bit wider so +1 never overflows
    logic             thr_reached;

    // A cycle counts as idle only when gating is enabled and nothing at all
    // asks for the clock.
    assign idle_cycle = auto_en_i && (idle_thr_i != '0) && !busy_i &&
                        !req_i && !wake_i && !force_on_i;

    // Events that leave GATED. busy_i is not one of them: the domain is
    // frozen while gated, so its busy indication is stale.
    assign wake_req = req_i || wake_i || force_on_i;

    // Use >= rather than == so that lowering idle_thr_i below the current
    // count while counting gates immediately instead of waiting for a wrap.
    assign idle_cnt_inc = {1'b0, idle_cnt_q} + 1'b1;
    assign thr_reached  = idle_cnt_inc >= {1'b0, idle_thr_i};

    // -----------------------------------------------------------------------
    // Next-state / counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = '0;

        unique case (state_q)
            ST_RUN: begin
                idle_cnt_d = '0;
                if (idle_cycle) begin
                    if (idle_thr_i == CNT_W'(1)) begin
                        state_d    = ST_GATED;
                        idle_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE_WAIT;
                        idle_cnt_d = CNT_W'(1);
                    end
                end
            end

            ST_IDLE_WAIT: begin
                if (!idle_cycle) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (thr_reached) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_inc[CNT_W-1:0];
                end
            end

            ST_GATED: begin
                idle_cnt_d = '0;
                if (wake_req) begin
                    state_d = ST_WAKE;
                end
            end

            ST_WAKE: begin
                // Settle window: every input except reset is ignored here.
                idle_cnt_d = '0;
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
            end
        endcase

        // The enable is computed from the next state so that the flop
        // drops or raises it on the same edge as the state transition.
        clk_en_d = (state_d != ST_GATED);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= clk_en_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign clk_en_o       = clk_en_q;
    assign ready_o        = (state_q == ST_RUN) || (state_q == ST_IDLE_WAIT);
    assign gated_o        = (state_q == ST_GATED);
    assign dbg_state_o    = state_q;
    assign dbg_idle_cnt_o = idle_cnt_q;
    assign dbg_wake_cnt_o = wake_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_ctrl
//
// Directed bench for clk_gate_ctrl with CNT_W=8 and WAKE_CYCLES=2.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so each check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_clk_gate_ctrl;

    localparam int CNT_W       = 8;
    localparam int WAKE_CYCLES = 2;
    localparam int WCW         = $clog2(WAKE_CYCLES) + 1;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_IW   = 2'd1;
    localparam logic [1:0] S_GATE = 2'd2;
    localparam logic [1:0] S_WAKE = 2'd3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             auto_en;
    logic [CNT_W-1:0] idle_thr;
    logic             busy;
    logic             req;
    logic             ready;
    logic             wake;
    logic             force_on;
    logic             clk_en;
    logic             gated;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_idle_cnt;
    logic [WCW-1:0]   dbg_wake_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    clk_gate_ctrl #(
        .CNT_W      (CNT_W),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .auto_en_i     (auto_en),
        .idle_thr_i    (idle_thr),
        .busy_i        (busy),
        .req_i         (req),
        .ready_o       (ready),
        .wake_i        (wake),
        .force_on_i    (force_on),
        .clk_en_o      (clk_en),
        .gated_o       (gated),
        .dbg_state_o   (dbg_state),
        .dbg_idle_cnt_o(dbg_idle_cnt),
        .dbg_wake_cnt_o(dbg_wake_cnt)
    );

    // -----------------------------------------------------------------------
    // driver tasks
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle(input logic [CNT_W-1:0] thr);
        auto_en  = 1'b1;
        idle_thr = thr;
        busy     = 1'b0;
        req      = 1'b0;
        wake     = 1'b0;
        force_on = 1'b0;
    endtask

    task automatic apply_reset(input logic [CNT_W-1:0] thr);
        drive_idle(thr);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // reset, then n idle samples, which gates the clock when n == thr
    task automatic go_gated(input logic [CNT_W-1:0] thr);
        apply_reset(thr);
        for (int i = 0; i < int'(thr); i++) tick();
    endtask

    // -----------------------------------------------------------------------
    // tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        drive_idle(8'd4);
        rst = 1'b1;
        tick();
        tests_run++;
        if ({clk_en, ready, gated, dbg_state, dbg_idle_cnt, dbg_wake_cnt} !==
            {1'b1, 1'b1, 1'b0, S_RUN, 8'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset: en=%b rdy=%b gated=%b st=%0d ic=%0d wc=%0d, want en=1 rdy=1 gated=0 st=0 ic=0 wc=0",
                     clk_en, ready, gated, dbg_state, dbg_idle_cnt, dbg_wake_cnt);
        end
        rst = 1'b0;
    endtask

    // thr=4: three idle samples keep the clock on, the fourth gates it
    task automatic test_idle_gate();
        apply_reset(8'd4);
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests_run++;
            if (clk_en !== 1'b1 || dbg_state !== S_IW || dbg_idle_cnt !== 8'(k)) begin
                tests_failed++;
                $display("FAIL idle_gate_count%0d: en=%b st=%0d ic=%0d, want en=1 st=1 ic=%0d",
                         k, clk_en, dbg_state, dbg_idle_cnt, k);
            end
        end
        tick();
        tests_run++;
        if (clk_en !== 1'b0 || gated !== 1'b1 || ready !== 1'b0 || dbg_idle_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL idle_gate_gated: en=%b gated=%b rdy=%b ic=%0d, want en=0 gated=1 rdy=0 ic=0",
                     clk_en, gated, ready, dbg_idle_cnt);
        end
        // busy and auto_en deassertion do not wake a gated domain
        busy    = 1'b1;
        auto_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if (clk_en !== 1'b0 || gated !== 1'b1) begin
            tests_failed++;
            $display("FAIL gated_ignores_busy: en=%b gated=%b, want en=0 gated=1", clk_en, gated);
        end
    endtask

    // busy on the third idle sample restarts the count
    task automatic test_busy_restart();
        apply_reset(8'd4);
        tick();
        tick();
        busy = 1'b1;
        tick();
        tests_run++;
        if (dbg_state !== S_RUN || dbg_idle_cnt !== 8'd0 || clk_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_restart: st=%0d ic=%0d en=%b, want st=0 ic=0 en=1",
                     dbg_state, dbg_idle_cnt, clk_en);
        end
        busy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (clk_en !== 1'b1 || dbg_idle_cnt !== 8'd3) begin
            tests_failed++;
            $display("FAIL busy_restart_3more: en=%b ic=%0d, want en=1 ic=3", clk_en, dbg_idle_cnt);
        end
        tick();
        tests_run++;
        if (clk_en !== 1'b0 || gated !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_restart_gate: en=%b gated=%b, want en=0 gated=1", clk_en, gated);
        end
    endtask

    // request into a gated domain: WAKE for 2 cycles, then the transfer
    task automatic test_req_wake();
        int xfers;
        int bad;
        go_gated(8'd4);
        req = 1'b1;
        tick();
        tests_run++;
        if (clk_en !== 1'b1 || ready !== 1'b0 || gated !== 1'b0 || dbg_state !== S_WAKE) begin
            tests_failed++;
            $display("FAIL req_wake_enter: en=%b rdy=%b gated=%b st=%0d, want en=1 rdy=0 gated=0 st=3",
                     clk_en, ready, gated, dbg_state);
        end
        tick();
        tests_run++;
        if (clk_en !== 1'b1 || ready !== 1'b0 || dbg_wake_cnt !== 2'd1) begin
            tests_failed++;
            $display("FAIL req_wake_settle: en=%b rdy=%b wc=%0d, want en=1 rdy=0 wc=1",
                     clk_en, ready, dbg_wake_cnt);
        end
        tick();
        tests_run++;
        if (ready !== 1'b1 || dbg_state !== S_RUN || clk_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL req_wake_ready: rdy=%b st=%0d en=%b, want rdy=1 st=0 en=1",
                     ready, dbg_state, clk_en);
        end
        // the held request completes now and keeps the clock on
        xfers = 0;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            if (req && ready) xfers++;
            tick();
            if (clk_en !== 1'b1) bad++;
        end
        tests_run++;
        if (xfers !== 20 || bad !== 0) begin
            tests_failed++;
            $display("FAIL req_hold: xfers=%0d regates=%0d, want xfers=20 regates=0", xfers, bad);
        end
        req = 1'b0;
    endtask

    // disabled gating never gates; thr=1 gates after a single sample
    task automatic test_disable();
        int bad;
        apply_reset(8'd0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (clk_en !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL thr_zero: gated_cycles=%0d, want 0", bad);
        end
        idle_thr = 8'd4;
        auto_en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (clk_en !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL auto_off: gated_cycles=%0d, want 0", bad);
        end
        drive_idle(8'd1);
        tick();
        tests_run++;
        if (clk_en !== 1'b0 || gated !== 1'b1) begin
            tests_failed++;
            $display("FAIL thr_one: en=%b gated=%b, want en=0 gated=1", clk_en, gated);
        end
    endtask

    task automatic test_force_on();
        int bad;
        go_gated(8'd4);
        force_on = 1'b1;
        tick();
        tests_run++;
        if (dbg_state !== S_WAKE || clk_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL force_wake: st=%0d en=%b, want st=3 en=1", dbg_state, clk_en);
        end
        tick();
        tick();
        tests_run++;
        if (dbg_state !== S_RUN || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL force_run: st=%0d rdy=%b, want st=0 rdy=1", dbg_state, ready);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (clk_en !== 1'b1 || dbg_state !== S_RUN) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL force_hold: bad_cycles=%0d, want 0", bad);
        end
        force_on = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (clk_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL force_release_early: en=%b, want 1", clk_en);
        end
        tick();
        tests_run++;
        if (clk_en !== 1'b0 || gated !== 1'b1) begin
            tests_failed++;
            $display("FAIL force_release_gate: en=%b gated=%b, want en=0 gated=1", clk_en, gated);
        end
    endtask

    task automatic test_reset_mid();
        go_gated(8'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({clk_en, ready, gated, dbg_state, dbg_idle_cnt, dbg_wake_cnt} !==
            {1'b1, 1'b1, 1'b0, S_RUN, 8'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_in_gated: en=%b rdy=%b gated=%b st=%0d ic=%0d wc=%0d, want 1 1 0 0 0 0",
                     clk_en, ready, gated, dbg_state, dbg_idle_cnt, dbg_wake_cnt);
        end
        go_gated(8'd4);
        wake = 1'b1;
        tick();
        wake = 1'b0;
        tick();   // mid-WAKE, wake_cnt = 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({clk_en, ready, gated, dbg_state, dbg_idle_cnt, dbg_wake_cnt} !==
            {1'b1, 1'b1, 1'b0, S_RUN, 8'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_in_wake: en=%b rdy=%b gated=%b st=%0d ic=%0d wc=%0d, want 1 1 0 0 0 0",
                     clk_en, ready, gated, dbg_state, dbg_idle_cnt, dbg_wake_cnt);
        end
    endtask

    task automatic test_simultaneous();
        // busy and wake together in GATED: wake wins
        go_gated(8'd4);
        busy = 1'b1;
        wake = 1'b1;
        tick();
        tests_run++;
        if (dbg_state !== S_WAKE || clk_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_and_wake: st=%0d en=%b, want st=3 en=1", dbg_state, clk_en);
        end
        // final idle sample with req: non-idle, stay clocked
        apply_reset(8'd4);
        for (int i = 0; i < 3; i++) tick();
        req = 1'b1;
        tick();
        tests_run++;
        if (dbg_state !== S_RUN || clk_en !== 1'b1 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL final_sample_req: st=%0d en=%b rdy=%b, want st=0 en=1 rdy=1",
                     dbg_state, clk_en, ready);
        end
        req = 1'b0;
    endtask

    task automatic test_thresholds();
        // lowering the threshold below the running count gates at once
        apply_reset(8'd8);
        for (int i = 0; i < 5; i++) tick();
        idle_thr = 8'd3;
        tick();
        tests_run++;
        if (gated !== 1'b1 || clk_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL thr_lowered: gated=%b en=%b, want gated=1 en=0", gated, clk_en);
        end
        // largest threshold: 254 samples still counting, the 255th gates
        apply_reset(8'd255);
        for (int i = 0; i < 254; i++) tick();
        tests_run++;
        if (dbg_state !== S_IW || dbg_idle_cnt !== 8'd254 || clk_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL thr_max_count: st=%0d ic=%0d en=%b, want st=1 ic=254 en=1",
                     dbg_state, dbg_idle_cnt, clk_en);
        end
        tick();
        tests_run++;
        if (gated !== 1'b1 || clk_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL thr_max_gate: gated=%b en=%b, want gated=1 en=0", gated, clk_en);
        end
    endtask

    // -----------------------------------------------------------------------
    // sequence and report
    // -----------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        drive_idle(8'd0);
        test_reset();
        test_idle_gate();
        test_busy_restart();
        test_req_wake();
        test_disable();
        test_force_on();
        test_reset_mid();
        test_simultaneous();
        test_thresholds();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
